stoch_grad_stream_gen: RTL

- Upstream feeder for the polar smooth-gradient accumulator. Produces its IN_SS / SIGN pair.
- Multiplies a stochastic error stream by a stochastic activation stream (AND).
- Nets the signed product bits over a fixed window, then replays the net magnitude as a thinned pulse train. Thinning is set by a learning-rate compare against an internal LFSR.
- Replay uses a single sign held for the whole window.

---
 rtl/stoch_grad_stream_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stoch_grad_stream_gen.sv
// ---------------------------------------------------------------------------
// stoch_grad_stream_gen
//
// Upstream feeder for the polar smooth-gradient accumulator. It produces the
// accumulator's IN_SS / SIGN pair.
//
// Operation:
//   - The stochastic error stream (DELTA_SS, DELTA_SIGN) is multiplied by the
//     stochastic activation stream (ACT_SS) with a plain AND.
//   - The signed product bits are netted over a window of 2^N_WIN training
//     cycles.
//   - At the end of each window the net magnitude is loaded into a replay
//     counter. The counter is then emitted as a thinned pulse train on
//     GRAD_SS.
//   - Thinning comes from comparing the learning rate LR against a free-running
//     Fibonacci LFSR.
//   - The sign of a replay is latched once per window (GRAD_SIGN). It never
//     changes inside a pulse train.
//
// Ports:
//   CLK                in   clock
//   INIT               in   asynchronous active-high reset
//   EN                 in   global enable; low freezes all state
//   CLK_TRAINING_flag  in   high = accumulate product bits, advance window
//   DELTA_SS           in   error magnitude stochastic bit
//   DELTA_SIGN         in   error sign, 1 = negative
//   ACT_SS             in   activation stochastic bit
//   LR[N_LR-1:0]       in   learning rate; 0 = no output pulses
//   GRAD_SS            out  registered gradient pulse
//   GRAD_SIGN          out  registered sign of current replay, 1 = negative
//   WINDOW_DONE        out  one-cycle pulse on the window-load edge
//   OVERRUN            out  sticky: a replay residual was discarded
//
// There is no valid/ready handshake here. Every enabled cycle carries one
// stream bit in and at most one pulse out.
// ---------------------------------------------------------------------------
module stoch_grad_stream_gen #(
  parameter int              N_WIN     = 4,
  parameter int              N_LR      = 8,
  parameter logic [N_LR-1:0] LFSR_SEED = 8'hA5
) (
  input  logic            CLK,
  input  logic            INIT,
  input  logic            EN,
  input  logic            CLK_TRAINING_flag,
  input  logic            DELTA_SS,
  input  logic            DELTA_SIGN,
  input  logic            ACT_SS,
  input  logic [N_LR-1:0] LR,
  output logic            GRAD_SS,
  output logic            GRAD_SIGN,
  output logic            WINDOW_DONE,
  output logic            OVERRUN
);

  // The accumulator spans -2^N_WIN .. +2^N_WIN, so it needs N_WIN+2 signed bits.
  // The magnitude peaks at 2^N_WIN, so it needs N_WIN+1 bits.
  localparam int ACC_W = N_WIN + 2;
  localparam int MAG_W = N_WIN + 1;

  localparam logic [N_WIN-1:0]        WCNT_LAST = {N_WIN{1'b1}};
  localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);

  // Registered state
  logic [N_WIN-1:0]        wcnt_q,        wcnt_d;
  logic signed [ACC_W-1:0] acc_q,         acc_d;
  logic [MAG_W-1:0]        emit_mag_q,    emit_mag_d;
  logic [N_LR-1:0]         lfsr_q,        lfsr_d;
  logic                    grad_ss_q,     grad_ss_d;
  logic                    grad_sign_q,   grad_sign_d;
  logic                    window_done_q, window_done_d;
  logic                    overrun_q,     overrun_d;

  // Combinational helpers
  logic                    prod;
  logic                    accum;
  logic                    load;
  logic                    gate;
  logic                    lfsr_fb;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_neg;
  logic [MAG_W-1:0]        mag_next;

  // Stochastic multiply of error magnitude and activation.
  assign prod  = DELTA_SS & ACT_SS;

  // Training cycles advance the window counter and fold in the product.
  assign accum = EN & CLK_TRAINING_flag;

  // The last counted cycle of a window is also the load cycle.
  assign load  = accum && (wcnt_q == WCNT_LAST);

  // A pulse may pass only when LR is nonzero and the LFSR value is not above LR.
  // Because the LFSR never reaches 0, LR = all-ones passes every cycle.
  assign gate  = (LR != '0) && (lfsr_q <= LR);

  // The polynomial is x^8+x^6+x^5+x^4+1. With a left shift, the feedback taps
  // are bits 7, 5, 4 and 3.
  assign lfsr_fb = lfsr_q[N_LR-1] ^ lfsr_q[N_LR-3] ^ lfsr_q[N_LR-4] ^ lfsr_q[N_LR-5];

  // The net sum includes the current cycle's product.
  // The load edge therefore sees the complete window.
  always_comb begin
    acc_next = acc_q;
    if (prod) begin
      if (DELTA_SIGN) acc_next = acc_q - ACC_ONE;
      else            acc_next = acc_q + ACC_ONE;
    end
  end

  assign acc_neg  = acc_next[ACC_W-1];
  assign mag_next = acc_neg ? MAG_W'(-acc_next) : MAG_W'(acc_next);

  // Next-state logic
  always_comb begin
    wcnt_d        = wcnt_q;
    acc_d         = acc_q;
    emit_mag_d    = emit_mag_q;
    lfsr_d        = lfsr_q;
    grad_sign_d   = grad_sign_q;
    overrun_d     = overrun_q;
    // Pulse-type outputs drop to 0 whenever they are not actively asserted,
    // including on disabled cycles.
    grad_ss_d     = 1'b0;
    window_done_d = 1'b0;

    if (EN) begin
      // The LFSR runs on every enabled cycle, independent of training.
      lfsr_d = {lfsr_q[N_LR-2:0], lfsr_fb};

      if (accum) begin
        wcnt_d = wcnt_q + N_WIN'(1);
        acc_d  = acc_next;
      end

      if (load) begin
        // Start a fresh replay. An unfinished replay is dropped and the
        // drop is flagged.
        if (emit_mag_q != '0) overrun_d = 1'b1;
        emit_mag_d    = mag_next;
        grad_sign_d   = acc_neg;
        acc_d         = '0;
        window_done_d = 1'b1;
      end else if ((emit_mag_q != '0) && gate) begin
        grad_ss_d  = 1'b1;
        emit_mag_d = emit_mag_q - MAG_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      wcnt_q        <= '0;
      acc_q         <= '0;
      emit_mag_q    <= '0;
      lfsr_q        <= LFSR_SEED;
      grad_ss_q     <= 1'b0;
      grad_sign_q   <= 1'b0;
      window_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      acc_q         <= acc_d;
      emit_mag_q    <= emit_mag_d;
      lfsr_q        <= lfsr_d;
      grad_ss_q     <= grad_ss_d;
      grad_sign_q   <= grad_sign_d;
      window_done_q <= window_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign GRAD_SS     = grad_ss_q;
  assign GRAD_SIGN   = grad_sign_q;
  assign WINDOW_DONE = window_done_q;
  assign OVERRUN     = overrun_q;

endmodule
